// File: rtl/c_element_sync_bank.sv
// rtl/c_element_sync_bank.sv - bank of clocked Muller C-elements for handshake merge/join
//
// Optional feature macro: C_ELEM_EDGE_FLAG_EN (adds rise_pulse / fall_pulse)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; loads RESET_VAL into every lane
//   in_vec     WIDTH*N_IN lane inputs; lane i input k is bit i*N_IN+k
//   c_out      registered C-element output per lane
//   agree      combinational: lane inputs currently all equal
//   rise_pulse one-cycle flag on the edge c_out[i] goes 0->1 (macro builds only)
//   fall_pulse one-cycle flag on the edge c_out[i] goes 1->0 (macro builds only)

module c_element_sync_bank #(
    parameter int   WIDTH     = 4,
    parameter int   N_IN      = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*N_IN-1:0]   in_vec,
    output logic [WIDTH-1:0]        c_out,
`ifdef C_ELEM_EDGE_FLAG_EN
    output logic [WIDTH-1:0]        rise_pulse,
    output logic [WIDTH-1:0]        fall_pulse,
`endif
    output logic [WIDTH-1:0]        agree
);

    logic [WIDTH-1:0] all_one;
    logic [WIDTH-1:0] all_zero;
    logic [WIDTH-1:0] c_next;

    always_comb begin
        all_one  = '0;
        all_zero = '0;
        for (int i = 0; i < WIDTH; i++) begin
            all_one[i]  = &in_vec[i*N_IN +: N_IN];
            all_zero[i] = ~|in_vec[i*N_IN +: N_IN];
        end
    end

    assign agree = all_one | all_zero;

    // all_one and all_zero are mutually exclusive, so set/clear never conflict;
    // a lane with mixed inputs keeps its current value.
    assign c_next = (c_out | all_one) & ~all_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_out <= {WIDTH{RESET_VAL}};
        end else begin
            c_out <= c_next;
        end
    end

`ifdef C_ELEM_EDGE_FLAG_EN
    // Flags are registered on the same edge as c_out, so they are high during
    // the cycle in which the new c_out value is first visible. Reset-driven
    // changes of c_out never raise a flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= c_next & ~c_out;
            fall_pulse <= ~c_next & c_out;
        end
    end
`endif

endmodule

// File: tb/tb_c_element_sync_bank.sv
// tb/tb_c_element_sync_bank.sv - directed self-checking bench for c_element_sync_bank

module tb_c_element_sync_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_a;
    logic [3:0] c_out_a;
    logic [3:0] agree_a;
    logic [5:0] in_b;
    logic [1:0] c_out_b;
    logic [1:0] agree_b;
`ifdef C_ELEM_EDGE_FLAG_EN
    logic [3:0] rise_a;
    logic [3:0] fall_a;
    logic [1:0] rise_b;
    logic [1:0] fall_b;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    c_element_sync_bank #(.WIDTH(4), .N_IN(2), .RESET_VAL(1'b0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_a),
        .c_out      (c_out_a),
`ifdef C_ELEM_EDGE_FLAG_EN
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
`endif
        .agree      (agree_a)
    );

    c_element_sync_bank #(.WIDTH(2), .N_IN(3), .RESET_VAL(1'b1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_vec     (in_b),
        .c_out      (c_out_b),
`ifdef C_ELEM_EDGE_FLAG_EN
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
`endif
        .agree      (agree_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags_a(input string tag, input logic [3:0] r, input logic [3:0] f);
`ifdef C_ELEM_EDGE_FLAG_EN
        check({tag, "_rise"}, 32'(rise_a), 32'(r));
        check({tag, "_fall"}, 32'(fall_a), 32'(f));
`endif
    endtask

    initial begin
        rst  = 1'b1;
        in_a = 8'hFF;
        in_b = 6'b000_000;
        tick();
        tick();
        check("rst_cout_a", 32'(c_out_a), 32'h0);
        check("rst_agree_a", 32'(agree_a), 32'hF);
        check("rst_cout_b", 32'(c_out_b), 32'h3);
        check("rst_agree_b", 32'(agree_b), 32'h3);
        flags_a("rst", 4'h0, 4'h0);

        rst = 1'b0;
        tick();
        check("release_a", 32'(c_out_a), 32'hF);
        check("release_b", 32'(c_out_b), 32'h0);
        flags_a("release", 4'hF, 4'h0);
`ifdef C_ELEM_EDGE_FLAG_EN
        check("release_b_fall", 32'(fall_b), 32'h3);
`endif

        // lane0 disagreement 01 then 10 must hold 1
        in_a = 8'hFD;
        in_b = 6'b110_110;
        #1;
        check("agree_mixed_a", 32'(agree_a), 32'hE);
        check("agree_mixed_b", 32'(agree_b), 32'h0);
        tick();
        check("hold01", 32'(c_out_a), 32'hF);
        check("hold110_b", 32'(c_out_b), 32'h0);
        flags_a("hold01", 4'h0, 4'h0);
        in_a = 8'hFE;
        tick();
        check("hold10", 32'(c_out_a), 32'hF);
        in_a = 8'hFC;
        tick();
        check("clear0", 32'(c_out_a), 32'hE);
        flags_a("clear0", 4'h0, 4'h1);

        // lane independence
        in_a = 8'h33;
        tick();
        check("setup0101", 32'(c_out_a), 32'h5);
        flags_a("setup0101", 4'h1, 4'hA);
        in_a = 8'hC7;
        #1;
        check("indep_agree", 32'(agree_a), 32'hD);
        tick();
        check("indep_cout", 32'(c_out_a), 32'h9);
        flags_a("indep", 4'h8, 4'h4);

        // same-edge flip of lane1 00 -> 11
        in_a = 8'hC3;
        tick();
        check("flip_pre", 32'(c_out_a), 32'h9);
        flags_a("flip_pre", 4'h0, 4'h0);
        in_a = 8'hCF;
        tick();
        check("flip_set", 32'(c_out_a), 32'hB);
        flags_a("flip_set", 4'h2, 4'h0);
        tick();
        check("flip_idem", 32'(c_out_a), 32'hB);
        flags_a("flip_idem", 4'h0, 4'h0);

        in_a = 8'hFF;
        tick();
        check("all_ones", 32'(c_out_a), 32'hF);
        flags_a("all_ones", 4'h4, 4'h0);

        // glitch between edges is ignored
        #4;
        in_a = 8'h00;
        #2;
        in_a = 8'hFF;
        tick();
        check("glitch", 32'(c_out_a), 32'hF);
        flags_a("glitch", 4'h0, 4'h0);

        // mid-operation reset
        rst = 1'b1;
        tick();
        check("midrst_a", 32'(c_out_a), 32'h0);
        check("midrst_b", 32'(c_out_b), 32'h3);
        flags_a("midrst", 4'h0, 4'h0);
        rst = 1'b0;
        tick();
        check("recover_a", 32'(c_out_a), 32'hF);
        check("recover_b_hold", 32'(c_out_b), 32'h3);
        flags_a("recover", 4'hF, 4'h0);
        tick();
        check("recover2_a", 32'(c_out_a), 32'hF);
        flags_a("recover2", 4'h0, 4'h0);

        in_b = 6'b000_000;
        tick();
        check("b_clear", 32'(c_out_b), 32'h0);
`ifdef C_ELEM_EDGE_FLAG_EN
        check("b_clear_fall", 32'(fall_b), 32'h3);
        check("b_clear_rise", 32'(rise_b), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
